// File: rtl/rca_chunked_seq.sv
// Multi-cycle ripple-carry adder/subtractor: adds CHUNK bits per clock and keeps the
// inter-slice carry in a register, behind valid/ready on both sides.
module rca_chunked_seq #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned CHUNK    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] bits_a,
  input  logic [BITWIDTH-1:0] bits_b,
  input  logic                carry_in,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] sum,
  output logic                carry_out,
  output logic                overflow
);

  localparam int unsigned NUM_CHUNKS = BITWIDTH / CHUNK;
  localparam int unsigned IdxW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHUNKS - 1);
  localparam int unsigned Msb        = BITWIDTH - 1;

  if ((CHUNK == 0) || (BITWIDTH % CHUNK != 0)) begin : gen_param_check
    $fatal(1, "rca_chunked_seq: CHUNK must divide BITWIDTH");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [BITWIDTH-1:0] a_q, b_q, sum_q;
  logic                c_q, carry_out_q, overflow_q, out_valid_q;
  logic [IdxW-1:0]     idx_q;
  logic [CHUNK-1:0]    a_chunk, b_chunk;
  logic [CHUNK:0]      chunk_sum;
  logic                last_chunk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)   state_d = StRun;
      StRun:   if (last_chunk) state_d = StDone;
      StDone:  if (out_ready)  state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = out_valid_q;
    sum       = sum_q;
    carry_out = carry_out_q;
    overflow  = overflow_q;
  end

  assign last_chunk = (idx_q == LastIdx);
  assign a_chunk    = a_q[32'(idx_q) * CHUNK +: CHUNK];
  assign b_chunk    = b_q[32'(idx_q) * CHUNK +: CHUNK];
  assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_d == StDone);
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            // Subtraction as A + ~B + 1; borrow-in folds into the inverted carry.
            a_q   <= bits_a;
            b_q   <= bits_b ^ {BITWIDTH{sub}};
            c_q   <= carry_in ^ sub;
            idx_q <= '0;
          end
        end
        StRun: begin
          sum_q[32'(idx_q) * CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          c_q <= chunk_sum[CHUNK];
          if (last_chunk) begin
            carry_out_q <= chunk_sum[CHUNK];
            overflow_q  <= (a_q[Msb] == b_q[Msb]) && (chunk_sum[CHUNK-1] != a_q[Msb]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
